// File: rtl/regfile_onehot_wr_if.sv
// Register file access bundle: one-hot write select/data, two read ports, diagnostics.
// Latency: reads are combinational; writes commit on the rising clock edge.
// Backpressure: none; every write select is consumed on the edge it is presented.
// Ports: wsel/wdata (write), raddr1/raddr2 -> rdata1/rdata2 (read), wsel_err/wr_count (status).
interface regfile_onehot_wr_if #(
    parameter int WIDTH = 64
);
    logic [31:0]      wsel;
    logic [WIDTH-1:0] wdata;
    logic [4:0]       raddr1;
    logic [4:0]       raddr2;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic             wsel_err;
    logic [7:0]       wr_count;

    modport master (
        output wsel, wdata, raddr1, raddr2,
        input  rdata1, rdata2, wsel_err, wr_count
    );

    modport slave (
        input  wsel, wdata, raddr1, raddr2,
        output rdata1, rdata2, wsel_err, wr_count
    );
endinterface

// File: rtl/regfile_onehot_wr.sv
// 32-entry register file, 2 combinational read ports, 1 write port driven by a one-hot decoder bus.
// Latency: reads 0 cycles (optional write-through bypass); writes visible after the rising edge.
// Backpressure: none; multi-hot write selects are dropped and latched into a sticky error flag.
// Ports: clk, reset_n (async active-low), bus (slave modport: wsel, wdata, raddr1/2, rdata1/2, wsel_err, wr_count).
module regfile_onehot_wr #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    regfile_onehot_wr_if.slave  bus
);

    logic [WIDTH-1:0] mem [32];
    logic             err_q;
    logic [7:0]       count_q;

    // wsel & (wsel - 1) clears the lowest set bit; anything left means two or more bits were set.
    logic wsel_any;
    logic wsel_multi;
    logic wsel_onehot;
    logic zero_hit;
    logic commit;

    assign wsel_any    = |bus.wsel;
    assign wsel_multi  = |(bus.wsel & (bus.wsel - 32'd1));
    assign wsel_onehot = wsel_any && !wsel_multi;
    // A write aimed at the hardwired zero register is discarded and does not count.
    assign zero_hit    = (ZERO_REG != 0) && bus.wsel[31];
    assign commit      = wsel_onehot && !zero_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < 32; i++) begin
                if (bus.wsel[i]) begin
                    mem[i] <= bus.wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (wsel_multi) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else if (commit && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign bus.wsel_err = err_q;
    assign bus.wr_count = count_q;

    // Read path: zero register overrides everything, then the optional write-through,
    // which only applies to a legal one-hot select.
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;
    logic             byp1;
    logic             byp2;
    logic             zero1;
    logic             zero2;

    assign stored1 = mem[bus.raddr1];
    assign stored2 = mem[bus.raddr2];
    assign byp1    = (BYPASS != 0) && wsel_onehot && bus.wsel[bus.raddr1];
    assign byp2    = (BYPASS != 0) && wsel_onehot && bus.wsel[bus.raddr2];
    assign zero1   = (ZERO_REG != 0) && (bus.raddr1 == 5'd31);
    assign zero2   = (ZERO_REG != 0) && (bus.raddr2 == 5'd31);

    assign bus.rdata1 = zero1 ? '0 : (byp1 ? bus.wdata : stored1);
    assign bus.rdata2 = zero2 ? '0 : (byp2 ? bus.wdata : stored2);

endmodule
